// File: rtl/minterm_code_pkg.sv
// Shared definitions for the X,Y,Z,K,M minterm code bus encoder.
//   state_t      : sequencer FSM states
//   IDLE_CODE    : bus value between symbols
//   SYM_MIN/MAX  : legal symbol index range
//   sym_legal    : 1 when a 4-bit index maps to a bus code
//   sym_to_code  : symbol index -> {X,Y,Z,K,M}; illegal indices give IDLE_CODE
package minterm_code_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [4:0] IDLE_CODE = 5'b00000;
  localparam logic [3:0] SYM_MIN   = 4'd1;
  localparam logic [3:0] SYM_MAX   = 4'd14;

  function automatic logic sym_legal(input logic [3:0] sym);
    return (sym >= SYM_MIN) && (sym <= SYM_MAX);
  endfunction

  function automatic logic [4:0] sym_to_code(input logic [3:0] sym);
    case (sym)
      4'd1:    return 5'b00010;
      4'd2:    return 5'b00011;
      4'd3:    return 5'b01010;
      4'd4:    return 5'b01011;
      4'd5:    return 5'b01111;
      4'd6:    return 5'b00110;
      4'd7:    return 5'b00100;
      4'd8:    return 5'b10101;
      4'd9:    return 5'b10100;
      4'd10:   return 5'b10001;
      4'd11:   return 5'b10011;
      4'd12:   return 5'b11011;
      4'd13:   return 5'b11001;
      4'd14:   return 5'b10010;
      default: return IDLE_CODE;
    endcase
  endfunction

endpackage

// File: rtl/sym_fifo.sv
// Synchronous symbol FIFO, DEPTH x W bits.
//   clk, rst    : clock, async active-high reset (empties the FIFO)
//   push, wdata : write request/data, ignored while full
//   pop         : advance read pointer, ignored while empty
//   head        : oldest entry, read straight from the storage flops
//   full, empty : occupancy flags from pointers with an extra wrap MSB
module sym_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW:0]             wr_ptr, rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  // Same slot, different lap -> full.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      mem    <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop && !empty)
        rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/minterm_code_sequencer.sv
// Transmit side of the 5-wire minterm code bus.
//   clk, rst        : clock, async active-high reset
//   in_valid/in_sym : symbol offer (1..14 legal)
//   in_ready        : FIFO has room (low while rst is high)
//   X,Y,Z,K,M       : registered code, X is MSB
//   busy            : work pending or bus still finishing a symbol
//   sym_done        : pulse on the final gap cycle of each symbol
//   err             : pulse when an illegal symbol is discarded
// The output register lags the FSM by one cycle, so a pop at edge t+1
// shows its code from edge t+2. Strobes are registered with the same lag.
module minterm_code_sequencer
  import minterm_code_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] in_sym,
  output logic       in_ready,
  output logic       X,
  output logic       Y,
  output logic       Z,
  output logic       K,
  output logic       M,
  output logic       busy,
  output logic       sym_done,
  output logic       err
);

  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

  state_t          state, next_state;
  logic [CW-1:0]   cnt;
  logic            push, pop, full, empty, head_legal;
  logic [3:0]      head;
  logic [4:0]      cur_code, code_q;
  logic            err_d, done_d;

  assign in_ready   = !full && !rst;
  assign push       = in_valid && in_ready;
  assign head_legal = sym_legal(head);

  sym_fifo #(.DEPTH(DEPTH), .W(4)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (in_sym),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    err_d      = 1'b0;
    done_d     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (head_legal) next_state = DRIVE;
          else            err_d      = 1'b1;
        end
      end
      DRIVE: begin
        if (cnt == HOLD_LAST) next_state = GAP;
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          done_d     = 1'b1;
          next_state = IDLE;
          // Chain straight into the next symbol with no extra idle cycle.
          if (!empty) begin
            pop = 1'b1;
            if (head_legal) next_state = DRIVE;
            else            err_d      = 1'b1;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      cur_code <= IDLE_CODE;
      code_q   <= IDLE_CODE;
      sym_done <= 1'b0;
      err      <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state != state)
        cnt <= '0;
      else if (((state == DRIVE) && (cnt != HOLD_LAST)) ||
               ((state == GAP)   && (cnt != GAP_LAST)))
        cnt <= cnt + CW'(1);
      if (pop && head_legal)
        cur_code <= sym_to_code(head);
      code_q   <= (state == DRIVE) ? cur_code : IDLE_CODE;
      sym_done <= done_d;
      err      <= err_d;
    end
  end

  assign {X, Y, Z, K, M} = code_q;
  // sym_done covers the lagged final gap cycle after the FSM is already IDLE.
  assign busy = (state != IDLE) || !empty || sym_done;

endmodule
